if_id_stage: RTL and testbench

- Instruction-fetch back end, directly downstream of the PC: takes the current PC and PC+4 and reads the instruction memory.
- Latches the fetched instruction into the IF/ID pipeline register for decode.
- Owns the instruction memory and a byte-serial loader FSM that fills it from the debug/UART path before execution starts.
- Honours the same step gating as the PC, plus IF/ID stall and flush.

---
 rtl/mips_pkg.sv | 7 +
 rtl/instr_mem.sv | 17 +
 rtl/if_id_stage.sv | 101 ++++++++++
 tb/tb_if_id_stage.sv | 125 ++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared datapath widths, instruction constants and loader states
package mips_pkg;
  localparam int NBITS = 32;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_READY} ld_state_t;
endpackage

// File: rtl/instr_mem.sv
// instr_mem: word-addressed instruction RAM, async read, sync write
module instr_mem #(
  parameter int NBITS = 32,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [NBITS-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [NBITS-1:0]  rdata
);
  logic [NBITS-1:0] mem [MEM_DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: instruction fetch, byte-serial program loader and IF/ID register
module if_id_stage
  import mips_pkg::*;
#(
  parameter int NBITS = mips_pkg::NBITS,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_step,
  input  logic             i_if_id_write,
  input  logic             i_flush,
  input  logic [NBITS-1:0] i_pc,
  input  logic [NBITS-1:0] i_pc_4,
  input  logic             i_load_start,
  input  logic             i_load_valid,
  input  logic [7:0]       i_load_byte,
  output logic [NBITS-1:0] o_instr,
  output logic [NBITS-1:0] o_pc_4,
  output logic             o_valid,
  output logic             o_halt,
  output logic             o_load_done
);
  ld_state_t state, nxt;
  logic [1:0] byte_cnt, byte_cnt_n;
  logic [ADDR_W-1:0] wr_addr, wr_addr_n;
  logic [23:0] shreg, shreg_n;
  logic [31:0] word;
  logic we;
  logic [NBITS-1:0] rdata, fetch;
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^i_pc[1:0];
  assign word = {shreg, i_load_byte};
  always_comb begin
    nxt = state;
    wr_addr_n = wr_addr;
    byte_cnt_n = byte_cnt;
    shreg_n = shreg;
    we = 1'b0;
    if (i_load_start) begin
      nxt = ST_LOAD;
      wr_addr_n = '0;
      byte_cnt_n = '0;
      shreg_n = '0;
    end else if (state == ST_LOAD && i_load_valid) begin
      shreg_n = word[23:0];
      byte_cnt_n = byte_cnt + 2'd1;
      if (byte_cnt == 2'd3) begin
        we = 1'b1;
        wr_addr_n = wr_addr + 1'b1;
        nxt = (word == HALT_INSTR || wr_addr == ADDR_W'(MEM_DEPTH - 1)) ? ST_READY : ST_LOAD;
      end
    end
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= ST_IDLE;
      wr_addr <= '0;
      byte_cnt <= '0;
      shreg <= '0;
      o_load_done <= 1'b0;
    end else begin
      state <= nxt;
      wr_addr <= wr_addr_n;
      byte_cnt <= byte_cnt_n;
      shreg <= shreg_n;
      o_load_done <= nxt == ST_READY;
    end
  end
  instr_mem #(.NBITS(NBITS), .MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk(i_clk),
    .we(we),
    .waddr(wr_addr),
    .wdata(NBITS'(word)),
    .raddr(i_pc[ADDR_W+1:2]),
    .rdata(rdata)
  );
  // addresses beyond the memory fetch as NOP rather than aliasing
  assign fetch = (|i_pc[NBITS-1:ADDR_W+2]) ? NBITS'(NOP_INSTR) : rdata;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset || !o_load_done) begin
      o_instr <= '0;
      o_pc_4 <= '0;
      o_valid <= 1'b0;
      o_halt <= 1'b0;
    end else if (i_step) begin
      if (i_flush) begin
        o_instr <= NBITS'(NOP_INSTR);
        o_pc_4 <= i_pc_4;
        o_valid <= 1'b0;
        o_halt <= 1'b0;
      end else if (i_if_id_write) begin
        o_instr <= fetch;
        o_pc_4 <= i_pc_4;
        o_valid <= 1'b1;
        o_halt <= fetch == NBITS'(HALT_INSTR);
      end
    end
  end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed scoreboard bench for the fetch stage and loader
module tb_if_id_stage;
  logic clk = 1'b0, rst = 1'b1;
  logic step = 1'b0, if_id_write = 1'b1, flush = 1'b0;
  logic [31:0] pc = '0, pc_4 = '0;
  logic load_start = 1'b0, load_valid = 1'b0;
  logic [7:0] load_byte = '0;
  logic [31:0] instr, opc_4;
  logic valid, halt, load_done;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_4;
    logic valid;
    logic halt;
    logic done;
  } exp_t;
  exp_t sb[$];
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  if_id_stage dut (
    .i_clk(clk), .i_reset(rst), .i_step(step), .i_if_id_write(if_id_write),
    .i_flush(flush), .i_pc(pc), .i_pc_4(pc_4), .i_load_start(load_start),
    .i_load_valid(load_valid), .i_load_byte(load_byte), .o_instr(instr),
    .o_pc_4(opc_4), .o_valid(valid), .o_halt(halt), .o_load_done(load_done)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, act, exp);
  endtask
  task automatic check_all(input string tag, input exp_t e);
    chk({tag, ".instr"}, instr, e.instr);
    chk({tag, ".pc_4"}, opc_4, e.pc_4);
    chk({tag, ".valid"}, 32'(valid), 32'(e.valid));
    chk({tag, ".halt"}, 32'(halt), 32'(e.halt));
    chk({tag, ".done"}, 32'(load_done), 32'(e.done));
  endtask
  task automatic push(input logic [31:0] i, input logic [31:0] p, input logic v, input logic h, input logic d);
    sb.push_back('{instr: i, pc_4: p, valid: v, halt: h, done: d});
  endtask
  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      check_all(tag, e);
    end
  endtask
  task automatic send_bytes(input logic [63:0] bytes, input string tag);
    for (int i = 0; i < 8; i++) begin
      load_valid = 1'b1;
      load_byte = bytes[63 - 8*i -: 8];
      push(32'h0, 32'h0, 1'b0, 1'b0, i == 7);
      tick(tag);
    end
    load_valid = 1'b0;
  endtask
  initial begin
    #2;
    check_all("reset", '0);
    @(posedge clk); #1;
    rst = 1'b0;
    step = 1'b1; pc = 32'h0; pc_4 = 32'h4;
    push(0, 0, 0, 0, 0); tick("preload0");
    push(0, 0, 0, 0, 0); tick("preload1");
    load_start = 1'b1;
    push(0, 0, 0, 0, 0); tick("start");
    load_start = 1'b0;
    send_bytes(64'h20010005_FFFFFFFF, "load");
    push(32'h20010005, 32'h4, 1, 0, 1); tick("fetch0");
    pc = 32'h4; pc_4 = 32'h8;
    push(32'hFFFFFFFF, 32'h8, 1, 1, 1); tick("fetch_halt");
    pc = 32'h1000; pc_4 = 32'h1004;
    push(32'h0, 32'h1004, 1, 0, 1); tick("fetch_oor");
    pc = 32'h3; pc_4 = 32'h7;
    push(32'h20010005, 32'h7, 1, 0, 1); tick("fetch_lsb");
    if_id_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pc = 32'(4 + 4*i); pc_4 = 32'(8 + 4*i);
      push(32'h20010005, 32'h7, 1, 0, 1); tick("stall");
    end
    step = 1'b0; flush = 1'b1; pc_4 = 32'h40;
    push(32'h20010005, 32'h7, 1, 0, 1); tick("nostep_flush");
    step = 1'b1; pc_4 = 32'h8;
    push(32'h0, 32'h8, 0, 0, 1); tick("flush");
    flush = 1'b0; if_id_write = 1'b1; pc = 32'h4; pc_4 = 32'h8;
    push(32'hFFFFFFFF, 32'h8, 1, 1, 1); tick("refetch_halt");
    load_start = 1'b1;
    push(32'hFFFFFFFF, 32'h8, 1, 1, 0); tick("reload_start");
    load_start = 1'b0; load_valid = 1'b1; load_byte = 8'h11;
    push(0, 0, 0, 0, 0); tick("partial0");
    load_byte = 8'h22;
    push(0, 0, 0, 0, 0); tick("partial1");
    load_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_all("midload_reset", '0);
    @(posedge clk); #1;
    rst = 1'b0;
    push(0, 0, 0, 0, 0); tick("after_reset");
    load_valid = 1'b1; load_byte = 8'h33;
    push(0, 0, 0, 0, 0); tick("idle_valid");
    load_valid = 1'b0; load_start = 1'b1;
    push(0, 0, 0, 0, 0); tick("restart");
    load_start = 1'b0; load_valid = 1'b1; load_byte = 8'h01;
    push(0, 0, 0, 0, 0); tick("partial2");
    load_valid = 1'b0; load_start = 1'b1;
    push(0, 0, 0, 0, 0); tick("restart_in_load");
    load_start = 1'b0;
    send_bytes(64'hAABBCCDD_FFFFFFFF, "load2");
    pc = 32'h0; pc_4 = 32'h4;
    push(32'hAABBCCDD, 32'h4, 1, 0, 1); tick("fetch_new0");
    pc = 32'h4; pc_4 = 32'h8;
    push(32'hFFFFFFFF, 32'h8, 1, 1, 1); tick("fetch_new1");
    total++;
    assert (sb.size() == 0) passed++;
    else $error("FAIL scoreboard_drain: observed %0d expected 0", sb.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
